// File: rtl/countdown_timer_core.sv
// MM:SS.hh BCD countdown timer: set in IDLE, run/pause on start, timed alarm with early acknowledge.
// Latency: one CLOCK_50 cycle from any pulse to the registered outputs; no backpressure, every pulse is consumed.
module countdown_timer_core #(
  parameter int ALARM_TICKS = 300
) (
  input  logic       CLOCK_50,
  input  logic       rst_db,
  input  logic       tick_100hz,
  input  logic       start_db,
  input  logic       inc_min_db,
  input  logic       inc_sec_db,
  output logic [3:0] q_hundredths,
  output logic [3:0] q_tenths,
  output logic [3:0] q_seconds,
  output logic [3:0] q_seconds_tens,
  output logic [3:0] q_minutes,
  output logic [3:0] q_minutes_tens,
  output logic       running,
  output logic       alarm
);

  localparam int CW = $clog2(ALARM_TICKS + 1);
  localparam logic [CW-1:0] ALARM_LAST = CW'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [3:0] tenths;
    logic [3:0] hund;
  } disp_t;

  state_t        state_q, state_d;
  disp_t         disp_q, disp_d;
  disp_t         preset_q, preset_d;
  logic [CW-1:0] acnt_q, acnt_d;
  logic          running_q, alarm_q;

  // Subtract 0.01 s; only called with a nonzero value, so the top digit never underflows.
  function automatic disp_t bcd_dec(input disp_t d);
    disp_t r;
    r = d;
    if (d.hund != 4'd0) begin
      r.hund = d.hund - 4'd1;
    end else begin
      r.hund = 4'd9;
      if (d.tenths != 4'd0) begin
        r.tenths = d.tenths - 4'd1;
      end else begin
        r.tenths = 4'd9;
        if (d.sec_ones != 4'd0) begin
          r.sec_ones = d.sec_ones - 4'd1;
        end else begin
          r.sec_ones = 4'd9;
          if (d.sec_tens != 4'd0) begin
            r.sec_tens = d.sec_tens - 4'd1;
          end else begin
            r.sec_tens = 4'd5;
            if (d.min_ones != 4'd0) begin
              r.min_ones = d.min_ones - 4'd1;
            end else begin
              r.min_ones = 4'd9;
              r.min_tens = d.min_tens - 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] inc_mod60(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] r;
    if (ones >= 4'd9) begin
      r = {(tens >= 4'd5) ? 4'd0 : tens + 4'd1, 4'd0};
    end else begin
      r = {tens, ones + 4'd1};
    end
    return r;
  endfunction

  always_comb begin
    state_d  = state_q;
    disp_d   = disp_q;
    preset_d = preset_q;
    acnt_d   = acnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_db && (disp_q != '0)) begin
          preset_d = disp_q;
          state_d  = RUN;
        end else if (inc_min_db || inc_sec_db) begin
          if (inc_min_db) begin
            {disp_d.min_tens, disp_d.min_ones} = inc_mod60(disp_q.min_tens, disp_q.min_ones);
          end
          if (inc_sec_db) begin
            {disp_d.sec_tens, disp_d.sec_ones} = inc_mod60(disp_q.sec_tens, disp_q.sec_ones);
          end
          disp_d.tenths = 4'd0;
          disp_d.hund   = 4'd0;
        end
      end
      RUN: begin
        // Start wins over a coincident tick, so pausing never loses or eats a hundredth.
        if (start_db) begin
          state_d = PAUSE;
        end else if (tick_100hz) begin
          if (disp_q == '0) begin
            state_d = ALARM;
            acnt_d  = '0;
          end else begin
            disp_d = bcd_dec(disp_q);
          end
        end
      end
      PAUSE: begin
        if (start_db) begin
          state_d = RUN;
        end
      end
      ALARM: begin
        if (start_db) begin
          state_d = IDLE;
          disp_d  = preset_q;
        end else if (tick_100hz) begin
          if (acnt_q == ALARM_LAST) begin
            state_d = IDLE;
            disp_d  = preset_q;
          end else begin
            acnt_d = acnt_q + CW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst_db) begin
    if (rst_db) begin
      state_q   <= IDLE;
      disp_q    <= '0;
      preset_q  <= '0;
      acnt_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      disp_q    <= disp_d;
      preset_q  <= preset_d;
      acnt_q    <= acnt_d;
      running_q <= (state_d == RUN);
      alarm_q   <= (state_d == ALARM);
    end
  end

  assign q_hundredths   = disp_q.hund;
  assign q_tenths       = disp_q.tenths;
  assign q_seconds      = disp_q.sec_ones;
  assign q_seconds_tens = disp_q.sec_tens;
  assign q_minutes      = disp_q.min_ones;
  assign q_minutes_tens = disp_q.min_tens;
  assign running        = running_q;
  assign alarm          = alarm_q;

  a_digit_range : assert property (@(posedge CLOCK_50) disable iff (rst_db)
    (disp_q.hund <= 4'd9) && (disp_q.tenths <= 4'd9) && (disp_q.sec_ones <= 4'd9) &&
    (disp_q.sec_tens <= 4'd5) && (disp_q.min_ones <= 4'd9) && (disp_q.min_tens <= 4'd5));

  a_flags_exclusive : assert property (@(posedge CLOCK_50) disable iff (rst_db)
    !(running_q && alarm_q));

endmodule

// File: tb/tb_countdown_timer_core.sv
// Bench for countdown_timer_core: centisecond-count reference model, per-cycle compare, directed and random stimulus.
module tb_countdown_timer_core;

  localparam int AT      = 300;
  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_ALARM = 3;

  logic       CLOCK_50   = 1'b0;
  logic       rst_db     = 1'b1;
  logic       tick_100hz = 1'b0;
  logic       start_db   = 1'b0;
  logic       inc_min_db = 1'b0;
  logic       inc_sec_db = 1'b0;
  logic [3:0] q_hundredths, q_tenths, q_seconds, q_seconds_tens, q_minutes, q_minutes_tens;
  logic       running, alarm;
  logic [23:0] dut_d;

  typedef struct packed {
    int val;     // display as total hundredths of a second
    int preset;
    int state;
    int acnt;
  } mdl_t;

  mdl_t mdl = '0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  always #5 CLOCK_50 = ~CLOCK_50;

  countdown_timer_core #(.ALARM_TICKS(AT)) dut (
    .CLOCK_50       (CLOCK_50),
    .rst_db         (rst_db),
    .tick_100hz     (tick_100hz),
    .start_db       (start_db),
    .inc_min_db     (inc_min_db),
    .inc_sec_db     (inc_sec_db),
    .q_hundredths   (q_hundredths),
    .q_tenths       (q_tenths),
    .q_seconds      (q_seconds),
    .q_seconds_tens (q_seconds_tens),
    .q_minutes      (q_minutes),
    .q_minutes_tens (q_minutes_tens),
    .running        (running),
    .alarm          (alarm)
  );

  assign dut_d = {q_minutes_tens, q_minutes, q_seconds_tens, q_seconds, q_tenths, q_hundredths};

  function automatic logic [23:0] to_bcd(input int v);
    int mm, ss, cs;
    mm = v / 6000;
    ss = (v / 100) % 60;
    cs = v % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cs / 10), 4'(cs % 10)};
  endfunction

  function automatic mdl_t model_next(input mdl_t m, input logic tk, input logic st,
                                      input logic im, input logic is);
    mdl_t n;
    int   mm, ss;
    n = m;
    case (m.state)
      S_IDLE: begin
        if (st && m.val != 0) begin
          n.preset = m.val;
          n.state  = S_RUN;
        end else if (im || is) begin
          mm = m.val / 6000;
          ss = (m.val / 100) % 60;
          if (im) mm = (mm + 1) % 60;
          if (is) ss = (ss + 1) % 60;
          n.val = mm * 6000 + ss * 100;
        end
      end
      S_RUN: begin
        if (st) n.state = S_PAUSE;
        else if (tk) begin
          if (m.val == 0) begin
            n.state = S_ALARM;
            n.acnt  = 0;
          end else begin
            n.val = m.val - 1;
          end
        end
      end
      S_PAUSE: begin
        if (st) n.state = S_RUN;
      end
      default: begin
        if (st) begin
          n.state = S_IDLE;
          n.val   = m.preset;
        end else if (tk) begin
          n.acnt = m.acnt + 1;
          if (n.acnt >= AT) begin
            n.state = S_IDLE;
            n.val   = m.preset;
          end
        end
      end
    endcase
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge CLOCK_50 or posedge rst_db);
      if (rst_db) mdl = '0;
      else        mdl = model_next(mdl, tick_100hz, start_db, inc_min_db, inc_sec_db);
    end
  end

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (chk_en) begin
        checks++;
        if (dut_d !== to_bcd(mdl.val)) begin
          errors++;
          $display("FAIL cycle_digits t=%0t dut=%h model=%h", $time, dut_d, to_bcd(mdl.val));
        end
        checks++;
        if ({running, alarm} !== {mdl.state == S_RUN, mdl.state == S_ALARM}) begin
          errors++;
          $display("FAIL cycle_flags t=%0t dut run/alarm=%b%b model=%b%b", $time, running, alarm,
                   mdl.state == S_RUN, mdl.state == S_ALARM);
        end
      end
    end
  end

  task automatic cyc(input logic tk, input logic st, input logic im, input logic is);
    @(negedge CLOCK_50);
    tick_100hz = tk;
    start_db   = st;
    inc_min_db = im;
    inc_sec_db = is;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic pulses(input int n, input logic im, input logic is);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, im, is);
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_db = 1'b1;
    @(negedge CLOCK_50);
    #2 rst_db = 1'b0;
  endtask

  task automatic chk_now(input string nm, input logic [23:0] exp_d, input logic exp_r, input logic exp_a);
    checks++;
    if (dut_d !== exp_d || running !== exp_r || alarm !== exp_a) begin
      errors++;
      $display("FAIL %s got=%h run=%b alarm=%b expected=%h run=%b alarm=%b",
               nm, dut_d, running, alarm, exp_d, exp_r, exp_a);
    end
  endtask

  // Checks the DUT and the model against a hand-computed value after the last applied cycle.
  task automatic chk_lit(input string nm, input logic [23:0] exp_d, input logic exp_r, input logic exp_a);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    chk_now(nm, exp_d, exp_r, exp_a);
    checks++;
    if (to_bcd(mdl.val) !== exp_d || (mdl.state == S_RUN) !== exp_r || (mdl.state == S_ALARM) !== exp_a) begin
      errors++;
      $display("FAIL model_%s got=%h state=%0d expected=%h run=%b alarm=%b",
               nm, to_bcd(mdl.val), mdl.state, exp_d, exp_r, exp_a);
    end
  endtask

  initial begin
    repeat (3) @(negedge CLOCK_50);
    chk_now("reset_hold", 24'h000000, 1'b0, 1'b0);
    chk_en = 1'b1;
    #2 rst_db = 1'b0;

    // Set and run
    pulses(1, 1'b1, 1'b0);
    pulses(5, 1'b0, 1'b1);
    chk_lit("set_idle", 24'h010500, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_lit("start_run", 24'h010500, 1'b1, 1'b0);
    ticks(1);
    chk_lit("first_tick", 24'h010499, 1'b1, 1'b0);
    pulses(2, 1'b1, 1'b1);
    chk_lit("set_ignored_run", 24'h010499, 1'b1, 1'b0);

    // Full borrow chain
    do_reset();
    pulses(10, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk_lit("borrow_chain", 24'h095999, 1'b1, 1'b0);

    // Reach zero, hold one tick, then alarm; full alarm timeout
    do_reset();
    pulses(1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(100);
    chk_lit("zero_hold", 24'h000000, 1'b1, 1'b0);
    ticks(1);
    chk_lit("alarm_rise", 24'h000000, 1'b0, 1'b1);
    ticks(AT - 1);
    chk_lit("alarm_last", 24'h000000, 1'b0, 1'b1);
    ticks(1);
    chk_lit("alarm_timeout", 24'h000100, 1'b0, 1'b0);

    // Early acknowledge
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(101);
    chk_lit("alarm_again", 24'h000000, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_lit("alarm_ack", 24'h000100, 1'b0, 1'b0);

    // Pause and resume, then start+tick together
    do_reset();
    pulses(30, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_lit("paused", 24'h003000, 1'b0, 1'b0);
    ticks(50);
    chk_lit("pause_hold", 24'h003000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(1);
    chk_lit("resume", 24'h002999, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk_lit("start_tick", 24'h002999, 1'b0, 1'b0);

    // Simultaneous set pulses, wraps, start at zero
    do_reset();
    pulses(59, 1'b0, 1'b1);
    pulses(1, 1'b1, 1'b1);
    chk_lit("both_sets", 24'h010000, 1'b0, 1'b0);
    do_reset();
    pulses(60, 1'b1, 1'b0);
    chk_lit("min_wrap", 24'h000000, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk_lit("start_zero", 24'h000000, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN and mid-ALARM, checked before the next clock edge
    pulses(2, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_db = 1'b1;
    #1 chk_now("async_run", 24'h000000, 1'b0, 1'b0);
    @(negedge CLOCK_50);
    #2 rst_db = 1'b0;
    pulses(1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(101);
    chk_lit("alarm_pre_rst", 24'h000000, 1'b0, 1'b1);
    #2 rst_db = 1'b1;
    #1 chk_now("async_alarm", 24'h000000, 1'b0, 1'b0);
    @(negedge CLOCK_50);
    #2 rst_db = 1'b0;
    ticks(AT);
    chk_lit("post_rst_idle", 24'h000000, 1'b0, 1'b0);

    // Randomized traffic against the model
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 999) < 2) begin
        do_reset();
      end else begin
        cyc($urandom_range(0, 1) == 1, $urandom_range(0, 99) < 3,
            $urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLOCK_50);
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
